// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access unit: access sizes, load
// funct3 codes, byte-enable patterns and the access FSM state type.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      DONE     = 2'd2
   } mau_state_e;

   // Access size as carried in store control [1:0] and load funct3 [1:0].
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   // Lane mask for an access of the given size at the given byte offset.
   function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                              input logic [1:0] offset);
      case (size)
         SIZE_BYTE: return BE_BYTE << offset;
         SIZE_HALF: return BE_HALF << offset;
         default:   return BE_WORD;
      endcase
   endfunction

   // Halves must sit on even addresses, words on multiples of four.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] offset);
      case (size)
         SIZE_BYTE: return 1'b0;
         SIZE_HALF: return offset[0];
         default:   return |offset;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load alignment: moves the addressed byte/half of a memory word down to
// bit 0 and sign- or zero-extends it according to the load funct3.
module mem_load_align
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [31:0] shifted;

   // Shift the addressed lane to the bottom, then extend to 32 bits.
   always_comb begin
      shifted = rdata >> {offset, 3'b000};
      case (funct3)
         F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
         F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
         F3_LBU:  data = {24'h0, shifted[7:0]};
         F3_LHU:  data = {16'h0, shifted[15:0]};
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit for the MEM stage. Issues one load or store per
// op over a REQ/ACK bus, stalling upstream until the access completes;
// misaligned halves/words raise a one-cycle MISALIGNED fault instead.
// Optional macro LSU_FORWARD_EN: forward the write-back result into the
// integer store data when it targets the same (non-zero) register.
module mem_access_unit
   import mem_pkg::*;
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] MEM_ALU_OUT,
   input  logic [31:0] MEM_REG_DATA2,
   input  logic [31:0] MEM_FREG_DATA2,
   input  logic        MEM_DATA_MEM_WRITE_DATA_SELECT,
   input  logic [2:0]  MEM_DATA_MEM_WRITE,
   input  logic [3:0]  MEM_DATA_MEM_READ,
   input  logic [4:0]  MEM_REG_READ_ADDR2,
   input  logic [4:0]  WB_REG_WRITE_ADDR,
   input  logic        WB_REG_WRITE_EN,
   input  logic [31:0] WB_WRITE_DATA,
   output logic        DMEM_REQ,
   output logic        DMEM_WE,
   output logic [31:0] DMEM_ADDR,
   output logic [3:0]  DMEM_BE,
   output logic [31:0] DMEM_WDATA,
   input  logic [31:0] DMEM_RDATA,
   input  logic        DMEM_ACK,
   output logic [31:0] LOAD_DATA,
   output logic        MEM_STALL,
   output logic        MISALIGNED
);

   mau_state_e  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  offset_q, offset_d;
   logic [31:0] load_data_q, load_data_d;

   logic        is_store, is_load, op_valid, op_misaligned, fwd_hit;
   logic [1:0]  op_size;
   logic [31:0] store_src, store_lanes, aligned_data;

   // A store wins when both enables are set.
   assign is_store      = MEM_DATA_MEM_WRITE[2];
   assign is_load       = MEM_DATA_MEM_READ[3];
   assign op_valid      = is_store | is_load;
   assign op_size       = is_store ? MEM_DATA_MEM_WRITE[1:0] : MEM_DATA_MEM_READ[1:0];
   assign op_misaligned = is_misaligned(op_size, MEM_ALU_OUT[1:0]);

`ifdef LSU_FORWARD_EN
   assign fwd_hit = !MEM_DATA_MEM_WRITE_DATA_SELECT && WB_REG_WRITE_EN &&
                    (WB_REG_WRITE_ADDR == MEM_REG_READ_ADDR2) &&
                    (WB_REG_WRITE_ADDR != 5'd0);
`else
   logic unused_wb;
   assign fwd_hit   = 1'b0;
   assign unused_wb = ^{WB_REG_WRITE_EN, WB_REG_WRITE_ADDR, MEM_REG_READ_ADDR2, WB_WRITE_DATA};
`endif

   // Select the store source and replicate it across every byte lane.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      store_src = MEM_DATA_MEM_WRITE_DATA_SELECT ? MEM_FREG_DATA2 : MEM_REG_DATA2;
      if (fwd_hit) store_src = WB_WRITE_DATA;
      case (op_size)
         SIZE_BYTE: store_lanes = {4{store_src[7:0]}};
         SIZE_HALF: store_lanes = {2{store_src[15:0]}};
         default:   store_lanes = store_src;
      endcase
   end

   mem_load_align u_load_align (
      .rdata  (DMEM_RDATA),
      .offset (offset_q),
      .funct3 (funct3_q),
      .data   (aligned_data)
   );

   // Next-state and stall/fault decode; bus fields are captured on launch.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      we_d        = we_q;
      funct3_d    = funct3_q;
      offset_d    = offset_q;
      load_data_d = load_data_q;
      MEM_STALL   = 1'b0;
      MISALIGNED  = 1'b0;
      case (state_q)
         IDLE: begin
            if (op_valid && !RESET) begin
               if (op_misaligned) begin
                  MISALIGNED = 1'b1;
               end else begin
                  MEM_STALL = 1'b1;
                  state_d   = WAIT_ACK;
                  addr_d    = {MEM_ALU_OUT[31:2], 2'b00};
                  be_d      = byte_enable(op_size, MEM_ALU_OUT[1:0]);
                  wdata_d   = store_lanes;
                  we_d      = is_store;
                  funct3_d  = MEM_DATA_MEM_READ[2:0];
                  offset_d  = MEM_ALU_OUT[1:0];
               end
            end
         end
         WAIT_ACK: begin
            MEM_STALL = 1'b1;
            if (DMEM_ACK) begin
               state_d = DONE;
               if (!we_q) load_data_d = aligned_data;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and bus registers with synchronous reset.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= IDLE;
         addr_q      <= 32'h0;
         be_q        <= BE_NONE;
         wdata_q     <= 32'h0;
         we_q        <= 1'b0;
         funct3_q    <= 3'b000;
         offset_q    <= 2'b00;
         load_data_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         be_q        <= be_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         funct3_q    <= funct3_d;
         offset_q    <= offset_d;
         load_data_q <= load_data_d;
      end
   end

   assign DMEM_REQ   = (state_q == WAIT_ACK);
   assign DMEM_WE    = we_q & DMEM_REQ;
   assign DMEM_ADDR  = addr_q;
   assign DMEM_BE    = be_q;
   assign DMEM_WDATA = wdata_q;
   assign LOAD_DATA  = load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a table of load/store/fault
// vectors with a scoreboard queue, plus hand sequences for stray ACKs and
// reset during an outstanding access. Define LSU_FORWARD_EN to match the RTL.
module tb_mem_access_unit;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] MEM_ALU_OUT, MEM_REG_DATA2, MEM_FREG_DATA2;
   logic        MEM_DATA_MEM_WRITE_DATA_SELECT;
   logic [2:0]  MEM_DATA_MEM_WRITE;
   logic [3:0]  MEM_DATA_MEM_READ;
   logic [4:0]  MEM_REG_READ_ADDR2, WB_REG_WRITE_ADDR;
   logic        WB_REG_WRITE_EN;
   logic [31:0] WB_WRITE_DATA;
   logic        DMEM_REQ, DMEM_WE;
   logic [31:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
   logic [3:0]  DMEM_BE;
   logic        DMEM_ACK;
   logic [31:0] LOAD_DATA;
   logic        MEM_STALL, MISALIGNED;

   always #5 CLK = ~CLK;

   mem_access_unit dut (
      .CLK(CLK), .RESET(RESET),
      .MEM_ALU_OUT(MEM_ALU_OUT), .MEM_REG_DATA2(MEM_REG_DATA2),
      .MEM_FREG_DATA2(MEM_FREG_DATA2),
      .MEM_DATA_MEM_WRITE_DATA_SELECT(MEM_DATA_MEM_WRITE_DATA_SELECT),
      .MEM_DATA_MEM_WRITE(MEM_DATA_MEM_WRITE), .MEM_DATA_MEM_READ(MEM_DATA_MEM_READ),
      .MEM_REG_READ_ADDR2(MEM_REG_READ_ADDR2), .WB_REG_WRITE_ADDR(WB_REG_WRITE_ADDR),
      .WB_REG_WRITE_EN(WB_REG_WRITE_EN), .WB_WRITE_DATA(WB_WRITE_DATA),
      .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
      .DMEM_BE(DMEM_BE), .DMEM_WDATA(DMEM_WDATA), .DMEM_RDATA(DMEM_RDATA),
      .DMEM_ACK(DMEM_ACK), .LOAD_DATA(LOAD_DATA),
      .MEM_STALL(MEM_STALL), .MISALIGNED(MISALIGNED)
   );

   typedef struct {
      string       name;
      logic [2:0]  wr;
      logic [3:0]  rd;
      logic        fsel;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [31:0] rdata;
      int          ack_wait;
      logic        wb_en;
      logic [4:0]  wb_addr;
      logic [4:0]  rs2;
      logic [31:0] wb_data;
      logic        mis;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_load;
   } vec_t;

   vec_t        vecs[$];
   vec_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_load = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic [2:0] wr, input logic [3:0] rd,
                               input logic fsel, input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [31:0] rdata, input int ack_wait, input logic mis,
                               input logic [31:0] exp_addr, input logic [3:0] exp_be,
                               input logic [31:0] exp_wdata, input logic [31:0] exp_load);
      vec_t v;
      v.name = name; v.wr = wr; v.rd = rd; v.fsel = fsel; v.addr = addr; v.sdata = sdata;
      v.rdata = rdata; v.ack_wait = ack_wait; v.mis = mis; v.exp_addr = exp_addr;
      v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_load = exp_load;
      v.wb_en = 1'b0; v.wb_addr = 5'd0; v.rs2 = 5'd0; v.wb_data = 32'h0;
      return v;
   endfunction

   task automatic clear_op();
      MEM_DATA_MEM_WRITE = 3'b000;
      MEM_DATA_MEM_READ  = 4'b0000;
      MEM_ALU_OUT        = 32'h0;
      WB_REG_WRITE_EN    = 1'b0;
   endtask

   // Present one op, play the memory side, and score the bus and result.
   task automatic run_op(input vec_t v);
      vec_t e;
      int   stall_cycles;
      @(posedge CLK); #1;
      MEM_ALU_OUT                    = v.addr;
      MEM_DATA_MEM_WRITE             = v.wr;
      MEM_DATA_MEM_READ              = v.rd;
      MEM_DATA_MEM_WRITE_DATA_SELECT = v.fsel;
      MEM_REG_DATA2                  = v.fsel ? ~v.sdata : v.sdata;
      MEM_FREG_DATA2                 = v.fsel ? v.sdata : ~v.sdata;
      WB_REG_WRITE_EN                = v.wb_en;
      WB_REG_WRITE_ADDR              = v.wb_addr;
      MEM_REG_READ_ADDR2             = v.rs2;
      WB_WRITE_DATA                  = v.wb_data;
      exp_q.push_back(v);
      @(negedge CLK);
      if (v.mis) begin
         e = exp_q.pop_front();
         check({e.name, "_misaligned"}, MISALIGNED, 1);
         check({e.name, "_mis_stall"}, MEM_STALL, 0);
         check({e.name, "_mis_req"}, DMEM_REQ, 0);
         @(posedge CLK); #1; clear_op();
         @(negedge CLK);
         check({e.name, "_mis_pulse_end"}, MISALIGNED, 0);
         check({e.name, "_mis_no_req"}, DMEM_REQ, 0);
         return;
      end
      stall_cycles = MEM_STALL ? 1 : 0;
      check({v.name, "_idle_req"}, DMEM_REQ, 0);
      for (int k = 0; k <= v.ack_wait; k++) begin
         @(posedge CLK); #1;
         DMEM_RDATA = v.rdata;
         DMEM_ACK   = (k == v.ack_wait);
         @(negedge CLK);
         if (MEM_STALL) stall_cycles++;
         e = exp_q[0];
         check($sformatf("%s_req%0d", e.name, k), DMEM_REQ, 1);
         check($sformatf("%s_addr%0d", e.name, k), DMEM_ADDR, e.exp_addr);
         check($sformatf("%s_we%0d", e.name, k), DMEM_WE, e.wr[2]);
         if (e.wr[2]) begin
            check($sformatf("%s_be%0d", e.name, k), DMEM_BE, e.exp_be);
            check($sformatf("%s_wdata%0d", e.name, k), DMEM_WDATA, e.exp_wdata);
         end
      end
      @(posedge CLK); #1;
      DMEM_ACK   = 1'b0;
      DMEM_RDATA = 32'hDEAD_0000;
      @(negedge CLK);
      e = exp_q.pop_front();
      if (!e.wr[2]) last_load = e.exp_load;
      check({e.name, "_done_stall"}, MEM_STALL, 0);
      check({e.name, "_done_req"}, DMEM_REQ, 0);
      check({e.name, "_load_data"}, LOAD_DATA, last_load);
      check({e.name, "_stall_cycles"}, stall_cycles, e.ack_wait + 2);
      @(posedge CLK); #1; clear_op();
      @(negedge CLK);
      check({e.name, "_idle_hold"}, LOAD_DATA, last_load);
      check({e.name, "_idle_no_req"}, DMEM_REQ, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      //                name        wr      rd       fs   addr        sdata         rdata         w  mis exp_addr     be       exp_wdata     exp_load
      vecs.push_back(mk("lw_100",   3'b000, 4'b1010, 0, 32'h100, 32'h0,        32'hDEADBEEF, 2, 0, 32'h100, 4'b1111, 32'h0,        32'hDEADBEEF));
      vecs.push_back(mk("lb_103",   3'b000, 4'b1000, 0, 32'h103, 32'h0,        32'h80FFFFFF, 0, 0, 32'h100, 4'b1000, 32'h0,        32'hFFFFFF80));
      vecs.push_back(mk("lbu_103",  3'b000, 4'b1100, 0, 32'h103, 32'h0,        32'h80FFFFFF, 1, 0, 32'h100, 4'b1000, 32'h0,        32'h00000080));
      vecs.push_back(mk("lh_102",   3'b000, 4'b1001, 0, 32'h102, 32'h0,        32'h80011234, 0, 0, 32'h100, 4'b1100, 32'h0,        32'hFFFF8001));
      vecs.push_back(mk("lhu_102",  3'b000, 4'b1101, 0, 32'h102, 32'h0,        32'h80011234, 3, 0, 32'h100, 4'b1100, 32'h0,        32'h00008001));
      vecs.push_back(mk("lb_101",   3'b000, 4'b1000, 0, 32'h101, 32'h0,        32'h00007F00, 0, 0, 32'h100, 4'b0010, 32'h0,        32'h0000007F));
      vecs.push_back(mk("lh_100",   3'b000, 4'b1001, 0, 32'h100, 32'h0,        32'h12347FFE, 1, 0, 32'h100, 4'b0011, 32'h0,        32'h00007FFE));
      vecs.push_back(mk("sh_202",   3'b101, 4'b0000, 0, 32'h202, 32'h0000ABCD, 32'h0,        0, 0, 32'h200, 4'b1100, 32'hABCDABCD, 32'h0));
      vecs.push_back(mk("sb_301",   3'b100, 4'b0000, 0, 32'h301, 32'h12345678, 32'h0,        1, 0, 32'h300, 4'b0010, 32'h78787878, 32'h0));
      vecs.push_back(mk("sb_503",   3'b100, 4'b0000, 0, 32'h503, 32'h000000AA, 32'h0,        0, 0, 32'h500, 4'b1000, 32'hAAAAAAAA, 32'h0));
      vecs.push_back(mk("sw_fp",    3'b110, 4'b0000, 1, 32'h400, 32'hCAFEF00D, 32'h0,        2, 0, 32'h400, 4'b1111, 32'hCAFEF00D, 32'h0));
      vecs.push_back(mk("rd_wr_st", 3'b110, 4'b1010, 0, 32'h600, 32'h5A5A5A5A, 32'h11111111, 0, 0, 32'h600, 4'b1111, 32'h5A5A5A5A, 32'h0));
      vecs.push_back(mk("lw_101",   3'b000, 4'b1010, 0, 32'h101, 32'h0,        32'h0,        0, 1, 32'h0,   4'b0000, 32'h0,        32'h0));
      vecs.push_back(mk("sh_203",   3'b101, 4'b0000, 0, 32'h203, 32'h1234,     32'h0,        0, 1, 32'h0,   4'b0000, 32'h0,        32'h0));
      vecs.push_back(mk("lhu_105",  3'b000, 4'b1101, 0, 32'h105, 32'h0,        32'h0,        0, 1, 32'h0,   4'b0000, 32'h0,        32'h0));
      vecs.push_back(mk("sw_102",   3'b110, 4'b0000, 0, 32'h102, 32'h1,        32'h0,        0, 1, 32'h0,   4'b0000, 32'h0,        32'h0));
`ifdef LSU_FORWARD_EN
      v = mk("sw_fwd_x5", 3'b110, 4'b0000, 0, 32'h900, 32'h0BADF00D, 32'h0, 0, 0, 32'h900, 4'b1111, 32'h12345678, 32'h0);
`else
      v = mk("sw_fwd_x5", 3'b110, 4'b0000, 0, 32'h900, 32'h0BADF00D, 32'h0, 0, 0, 32'h900, 4'b1111, 32'h0BADF00D, 32'h0);
`endif
      v.wb_en = 1'b1; v.wb_addr = 5'd5; v.rs2 = 5'd5; v.wb_data = 32'h12345678;
      vecs.push_back(v);
      v = mk("sw_fwd_x0", 3'b110, 4'b0000, 0, 32'h904, 32'h0BADF00D, 32'h0, 0, 0, 32'h904, 4'b1111, 32'h0BADF00D, 32'h0);
      v.wb_en = 1'b1; v.wb_addr = 5'd0; v.rs2 = 5'd0; v.wb_data = 32'h12345678;
      vecs.push_back(v);
      v = mk("sw_fwd_fp", 3'b110, 4'b0000, 1, 32'h908, 32'h600DCAFE, 32'h0, 0, 0, 32'h908, 4'b1111, 32'h600DCAFE, 32'h0);
      v.wb_en = 1'b1; v.wb_addr = 5'd7; v.rs2 = 5'd7; v.wb_data = 32'h12345678;
      vecs.push_back(v);

      RESET = 1'b1;
      clear_op();
      MEM_REG_DATA2 = 32'h0; MEM_FREG_DATA2 = 32'h0; MEM_DATA_MEM_WRITE_DATA_SELECT = 1'b0;
      MEM_REG_READ_ADDR2 = 5'd0; WB_REG_WRITE_ADDR = 5'd0; WB_WRITE_DATA = 32'h0;
      DMEM_RDATA = 32'h0; DMEM_ACK = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_req", DMEM_REQ, 0);
      check("rst_we", DMEM_WE, 0);
      check("rst_be", DMEM_BE, 0);
      check("rst_addr", DMEM_ADDR, 0);
      check("rst_wdata", DMEM_WDATA, 0);
      check("rst_load", LOAD_DATA, 0);
      check("rst_stall", MEM_STALL, 0);
      check("rst_mis", MISALIGNED, 0);
      @(posedge CLK); #1; RESET = 1'b0;

      foreach (vecs[i]) run_op(vecs[i]);

      // A stray ACK while idle must not start or complete anything.
      @(posedge CLK); #1; DMEM_ACK = 1'b1; DMEM_RDATA = 32'h13579BDF;
      @(negedge CLK);
      check("stray_ack_req", DMEM_REQ, 0);
      check("stray_ack_stall", MEM_STALL, 0);
      @(posedge CLK); #1; DMEM_ACK = 1'b0;
      @(negedge CLK);
      check("stray_ack_load", LOAD_DATA, last_load);
      check("stray_ack_req2", DMEM_REQ, 0);

      // Reset while waiting for ACK abandons the access; the late ACK is dropped.
      @(posedge CLK); #1;
      MEM_ALU_OUT = 32'h800; MEM_DATA_MEM_READ = 4'b1010;
      @(negedge CLK);
      check("midrst_launch_stall", MEM_STALL, 1);
      @(posedge CLK); #1; RESET = 1'b1; clear_op();
      @(negedge CLK);
      check("midrst_wait_req", DMEM_REQ, 1);
      @(posedge CLK); #1; RESET = 1'b0; DMEM_ACK = 1'b1; DMEM_RDATA = 32'hFFFFFFFF;
      @(negedge CLK);
      check("midrst_req", DMEM_REQ, 0);
      check("midrst_stall", MEM_STALL, 0);
      check("midrst_load", LOAD_DATA, 0);
      check("midrst_addr", DMEM_ADDR, 0);
      check("midrst_be", DMEM_BE, 0);
      check("midrst_wdata", DMEM_WDATA, 0);
      check("midrst_we", DMEM_WE, 0);
      @(posedge CLK); #1; DMEM_ACK = 1'b0;
      @(negedge CLK);
      check("midrst_late_ack_load", LOAD_DATA, 0);
      check("midrst_late_ack_req", DMEM_REQ, 0);
      last_load = 32'h0;

      run_op(mk("lw_after_rst", 3'b000, 4'b1010, 0, 32'h104, 32'h0, 32'h0F0F0F0F, 0, 0,
                32'h104, 4'b1111, 32'h0, 32'h0F0F0F0F));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
